// File: rtl/uart_cmd_decoder.sv
// Framed register read/write command decoder fed by a UART receiver byte stream.
// Validates the opcode and the XOR checksum and enforces an inter-byte timeout.
module uart_cmd_decoder #(
  parameter int          TIMEOUT  = 330000,
  parameter logic [7:0]  SYNC     = 8'hA5,
  parameter logic [7:0]  OP_WRITE = 8'h57,
  parameter logic [7:0]  OP_READ  = 8'h52
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] cmd_addr,
  output logic [7:0]  cmd_wdata,
  output logic        cmd_write,
  output logic        cmd_read,
  output logic        cmd_err,
  output logic [1:0]  err_cause
);

  typedef enum logic [2:0] {
    IDLE, OPCODE, ADDR_HI, ADDR_LO, DATA, CHECK
  } state_t;

  localparam logic [19:0] CNT_LAST = 20'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [19:0] cnt, cnt_next;
  logic [7:0]  csum, csum_next;
  logic        is_write, is_write_next;
  logic [15:0] addr_sh, addr_sh_next;
  logic [7:0]  data_sh, data_sh_next;
  logic [15:0] cmd_addr_next;
  logic [7:0]  cmd_wdata_next;
  logic        cmd_write_next, cmd_read_next, cmd_err_next;
  logic [1:0]  err_cause_next;
  logic        timeout;

  // A byte arriving on the expiry cycle suppresses the timeout.
  assign timeout = (state != IDLE) && (cnt == CNT_LAST) && !rx_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      csum      <= '0;
      is_write  <= 1'b0;
      addr_sh   <= '0;
      data_sh   <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_write <= 1'b0;
      cmd_read  <= 1'b0;
      cmd_err   <= 1'b0;
      err_cause <= 2'b00;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      csum      <= csum_next;
      is_write  <= is_write_next;
      addr_sh   <= addr_sh_next;
      data_sh   <= data_sh_next;
      cmd_addr  <= cmd_addr_next;
      cmd_wdata <= cmd_wdata_next;
      cmd_write <= cmd_write_next;
      cmd_read  <= cmd_read_next;
      cmd_err   <= cmd_err_next;
      err_cause <= err_cause_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = (state == IDLE || rx_valid) ? 20'd0 : cnt + 20'd1;
    csum_next      = csum;
    is_write_next  = is_write;
    addr_sh_next   = addr_sh;
    data_sh_next   = data_sh;
    cmd_addr_next  = cmd_addr;
    cmd_wdata_next = cmd_wdata;
    cmd_write_next = 1'b0;
    cmd_read_next  = 1'b0;
    cmd_err_next   = 1'b0;
    err_cause_next = err_cause;

    if (timeout) begin
      state_next     = IDLE;
      cmd_err_next   = 1'b1;
      err_cause_next = 2'b11;
    end else if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == SYNC) begin
            state_next = OPCODE;
            csum_next  = 8'h00;
          end
        end
        OPCODE: begin
          csum_next = csum ^ rx_data;
          if (rx_data == OP_WRITE) begin
            state_next    = ADDR_HI;
            is_write_next = 1'b1;
          end else if (rx_data == OP_READ) begin
            state_next    = ADDR_HI;
            is_write_next = 1'b0;
          end else begin
            state_next     = IDLE;
            cmd_err_next   = 1'b1;
            err_cause_next = 2'b01;
          end
        end
        ADDR_HI: begin
          csum_next          = csum ^ rx_data;
          addr_sh_next[15:8] = rx_data;
          state_next         = ADDR_LO;
        end
        ADDR_LO: begin
          csum_next         = csum ^ rx_data;
          addr_sh_next[7:0] = rx_data;
          state_next        = is_write ? DATA : CHECK;
        end
        DATA: begin
          csum_next    = csum ^ rx_data;
          data_sh_next = rx_data;
          state_next   = CHECK;
        end
        CHECK: begin
          state_next = IDLE;
          if (rx_data == csum) begin
            cmd_addr_next = addr_sh;
            if (is_write) begin
              cmd_wdata_next = data_sh;
              cmd_write_next = 1'b1;
            end else begin
              cmd_read_next = 1'b1;
            end
          end else begin
            cmd_err_next   = 1'b1;
            err_cause_next = 2'b10;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with hand-computed frames and checksums.
module tb_uart_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        cmd_write, cmd_read, cmd_err;
  logic [1:0]  err_cause;

  int checks = 0;
  int errors = 0;
  int n_write = 0, n_read = 0, n_err = 0;
  int base_w, base_r, base_e;
  logic saw_err;

  uart_cmd_decoder #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_write(cmd_write),
    .cmd_read(cmd_read), .cmd_err(cmd_err), .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobe counters plus a per-cycle exclusivity check.
  always @(posedge clk) begin
    if (!rst) begin
      if (cmd_write) n_write <= n_write + 1;
      if (cmd_read)  n_read  <= n_read + 1;
      if (cmd_err)   n_err   <= n_err + 1;
      if (32'(cmd_write) + 32'(cmd_read) + 32'(cmd_err) > 1)
        check("strobe_onehot", {29'd0, cmd_write, cmd_read, cmd_err}, 32'd0);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(3);
    check("rst_addr", 32'(cmd_addr), 32'h0);
    check("rst_wdata", 32'(cmd_wdata), 32'h0);
    check("rst_strobes", {29'd0, cmd_write, cmd_read, cmd_err}, 32'h0);
    check("rst_cause", 32'(err_cause), 32'h0);
    rst = 1'b0;
    idle(2);

    // Write frame
    send_byte(8'hA5); send_byte(8'h57); send_byte(8'h12);
    send_byte(8'h34); send_byte(8'h5A); send_byte(8'h2B);
    check("wr_strobe", {29'd0, cmd_write, cmd_read, cmd_err}, 32'b100);
    check("wr_addr", 32'(cmd_addr), 32'h1234);
    check("wr_wdata", 32'(cmd_wdata), 32'h5A);
    idle(1);
    check("wr_one_cycle", 32'(cmd_write), 32'h0);

    // Read after write
    send_byte(8'hA5); send_byte(8'h52); send_byte(8'h80);
    send_byte(8'h01); send_byte(8'hD3);
    check("rd_strobe", {29'd0, cmd_write, cmd_read, cmd_err}, 32'b010);
    check("rd_addr", 32'(cmd_addr), 32'h8001);
    check("rd_wdata_kept", 32'(cmd_wdata), 32'h5A);
    idle(1);
    check("rd_one_cycle", 32'(cmd_read), 32'h0);

    // Checksum error
    send_byte(8'hA5); send_byte(8'h57); send_byte(8'h12);
    send_byte(8'h34); send_byte(8'h5A); send_byte(8'h2C);
    check("cs_strobe", {29'd0, cmd_write, cmd_read, cmd_err}, 32'b001);
    check("cs_cause", 32'(err_cause), 32'h2);
    check("cs_addr_kept", 32'(cmd_addr), 32'h8001);
    check("cs_wdata_kept", 32'(cmd_wdata), 32'h5A);
    idle(1);
    send_byte(8'hA5); send_byte(8'h52); send_byte(8'h80);
    send_byte(8'h01); send_byte(8'hD3);
    check("cs_then_rd", {29'd0, cmd_write, cmd_read, cmd_err}, 32'b010);
    check("cs_cause_holds", 32'(err_cause), 32'h2);
    idle(1);

    // Bad opcode with leading garbage
    base_w = n_write; base_r = n_read; base_e = n_err;
    send_byte(8'h00); send_byte(8'hFF);
    check("garbage_silent", {29'd0, cmd_write, cmd_read, cmd_err}, 32'b000);
    send_byte(8'hA5); send_byte(8'h41);
    check("op_err", {29'd0, cmd_write, cmd_read, cmd_err}, 32'b001);
    check("op_cause", 32'(err_cause), 32'h1);
    send_byte(8'h57);
    idle(3);
    check("op_write_cnt", 32'(n_write - base_w), 32'd0);
    check("op_read_cnt", 32'(n_read - base_r), 32'd0);
    check("op_err_cnt", 32'(n_err - base_e), 32'd1);

    // Timeout: error exactly 16 cycles after the edge that took the 52
    send_byte(8'hA5); send_byte(8'h52);
    saw_err = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      saw_err = saw_err | cmd_err;
    end
    check("to_no_early_err", 32'(saw_err), 32'h0);
    idle(1);
    check("to_err", {29'd0, cmd_write, cmd_read, cmd_err}, 32'b001);
    check("to_cause", 32'(err_cause), 32'h3);
    idle(1);
    check("to_one_cycle", 32'(cmd_err), 32'h0);

    // Byte on the expiry cycle wins and the frame continues
    base_e = n_err;
    send_byte(8'hA5); send_byte(8'h52);
    idle(15);
    send_byte(8'h12);
    check("to_byte_wins", 32'(cmd_err), 32'h0);
    send_byte(8'h34); send_byte(8'h74);
    check("to_late_rd", {29'd0, cmd_write, cmd_read, cmd_err}, 32'b010);
    check("to_late_addr", 32'(cmd_addr), 32'h1234);
    idle(1);
    check("to_late_no_err", 32'(n_err - base_e), 32'd0);

    // Asynchronous reset mid-frame
    send_byte(8'hA5); send_byte(8'h57); send_byte(8'h12);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_addr", 32'(cmd_addr), 32'h0);
    check("mid_rst_outs", {21'd0, cmd_wdata, cmd_write, cmd_read, cmd_err}, 32'h0);
    check("mid_rst_cause", 32'(err_cause), 32'h0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Two frames back to back, consecutive-cycle rx_valid
    base_w = n_write; base_r = n_read; base_e = n_err;
    send_byte(8'hA5); send_byte(8'h57); send_byte(8'hAB);
    send_byte(8'hCD); send_byte(8'h77); send_byte(8'h46);
    check("b2b_wr", {29'd0, cmd_write, cmd_read, cmd_err}, 32'b100);
    check("b2b_wr_addr", 32'(cmd_addr), 32'hABCD);
    send_byte(8'hA5); send_byte(8'h52); send_byte(8'h00);
    send_byte(8'h10); send_byte(8'h42);
    check("b2b_rd", {29'd0, cmd_write, cmd_read, cmd_err}, 32'b010);
    check("b2b_rd_addr", 32'(cmd_addr), 32'h0010);
    check("b2b_rd_wdata", 32'(cmd_wdata), 32'h77);
    idle(2);
    check("b2b_write_cnt", 32'(n_write - base_w), 32'd1);
    check("b2b_read_cnt", 32'(n_read - base_r), 32'd1);
    check("b2b_err_cnt", 32'(n_err - base_e), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
